// File: rtl/decimal_digit_scanner.sv
// decimal_digit_scanner: binary-to-BCD converter (iterative shift-add-3) feeding
// a display register, plus a free-running digit scanner that emits one
// decoder digit code and a one-hot digit select per refresh slot.
module decimal_digit_scanner #(
    parameter int DIGITS      = 4,
    parameter int WIDTH       = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              Clock,
    input  logic              ResetN,
    input  logic [WIDTH-1:0]  Value,
    input  logic              Load,
    input  logic              BlankZeros,
    output logic              Busy,
    output logic              Done,
    output logic              Overflow,
    output logic [9:0]        Number,
    output logic [DIGITS-1:0] DigitSelect
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int IDX_W = $clog2(DIGITS);
    localparam int PRE_W = $clog2(REFRESH_DIV);

    // Largest value that fits in DIGITS decimal digits (10^DIGITS - 1).
    function automatic logic [63:0] max_decimal(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MAX_VALUE = max_decimal(DIGITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   bin_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [BCD_W-1:0]   bcd_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;
    logic               busy_q;
    logic               done_q;
    // Display digits; nibble 4'hF marks a blanked digit (never produced by BCD).
    logic [BCD_W-1:0]   disp_q;
    logic [PRE_W-1:0]   pre_q;
    logic [IDX_W-1:0]   idx_q;
    logic [DIGITS-1:0]  blank_mask;
    logic [3:0]         cur_digit;
    logic               zero_run;

    // Add-3 correction of every BCD nibble that is 5 or more, ahead of the shift.
    // NOTE: combinational blocks assign a default first so no latch is inferred.
    always_comb begin
        bcd_d = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM with registered Busy/Done/Overflow and the display register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            disp_q  <= '0;
        end else begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (Load) begin
                        bin_q   <= Value;
                        bcd_q   <= '0;
                        cnt_q   <= CNT_W'(WIDTH);
                        ovf_q   <= (64'(Value) > MAX_VALUE);
                        state_q <= S_SHIFT;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    if (cnt_q != '0) begin
                        {bcd_q, bin_q} <= {bcd_d[BCD_W-2:0], bin_q, 1'b0};
                        cnt_q          <= cnt_q - CNT_W'(1);
                        busy_q         <= 1'b1;
                    end else begin
                        // All bits shifted in: publish result (or blanks on overflow).
                        disp_q  <= ovf_q ? '1 : bcd_q;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Free-running refresh prescaler and digit index, independent of the FSM.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (pre_q == PRE_W'(REFRESH_DIV - 1)) begin
            pre_q <= '0;
            idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

    // Leading-zero mask: digit i>0 is blankable when it and all higher digits are 0.
    always_comb begin
        zero_run   = 1'b1;
        blank_mask = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run      = zero_run && (disp_q[4*i +: 4] == 4'd0);
            blank_mask[i] = zero_run;
        end
    end

    // Digit code for the currently scanned digit.
    always_comb begin
        cur_digit = disp_q[4*int'(idx_q) +: 4];
        if ((BlankZeros && blank_mask[idx_q]) || (cur_digit > 4'd9)) begin
            Number = '1;
        end else if (cur_digit == 4'd0) begin
            Number = '0;
        end else begin
            Number = 10'd1 << (cur_digit - 4'd1);
        end
    end

    assign DigitSelect = DIGITS'(1) << idx_q;
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign Overflow    = ovf_q;

endmodule

// File: tb/tb_decimal_digit_scanner.sv
// Scoreboard bench for decimal_digit_scanner: stimulus pushes the expected
// decimal digits per accepted load; a monitor pops them on Done and checks the
// scanned Number/DigitSelect every cycle against a cycle-count scan model.
module tb_decimal_digit_scanner;

    localparam int D = 4;
    localparam int W = 14;
    localparam int R = 4;

    logic          Clock = 1'b0;
    logic          ResetN = 1'b0;
    logic [W-1:0]  Value = '0;
    logic          Load = 1'b0;
    logic          BlankZeros = 1'b0;
    logic          Busy, Done, Overflow;
    logic [9:0]    Number;
    logic [D-1:0]  DigitSelect;

    decimal_digit_scanner #(.DIGITS(D), .WIDTH(W), .REFRESH_DIV(R)) dut (
        .Clock      (Clock),
        .ResetN     (ResetN),
        .Value      (Value),
        .Load       (Load),
        .BlankZeros (BlankZeros),
        .Busy       (Busy),
        .Done       (Done),
        .Overflow   (Overflow),
        .Number     (Number),
        .DigitSelect(DigitSelect)
    );

    always #5 Clock = ~Clock;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int digits[D];   // -1 = blank
        bit ovf;
        int load_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t popped;
    int   model_dig[D];
    int   busy_cnt = 0;
    int   cyc = 0;       // free-running edge count
    int   n = 0;         // edges since reset release, drives the scan model

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int code_of(input int d);
        if (d < 0)  return 1023;
        if (d == 0) return 0;
        return 1 << (d - 1);
    endfunction

    function automatic int exp_number(input int idx);
        bit all_zero;
        all_zero = 1'b1;
        for (int i = idx; i < D; i++) begin
            if (model_dig[i] != 0) all_zero = 1'b0;
        end
        if (BlankZeros && idx > 0 && all_zero) return 1023;
        return code_of(model_dig[idx]);
    endfunction

    always @(posedge Clock) cyc++;

    always @(posedge Clock or negedge ResetN) begin
        if (!ResetN) n = 0;
        else         n = n + 1;
    end

    // Monitor: consumes expectations on Done and checks the scan every cycle.
    always @(negedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            sb.delete();
            for (int i = 0; i < D; i++) model_dig[i] = 0;
            busy_cnt = 0;
        end else begin
            if (Done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    popped = sb.pop_front();
                    check("done_latency", cyc - popped.load_cyc, W + 1);
                    check("busy_cycles", busy_cnt, W);
                    check("overflow", int'(Overflow), int'(popped.ovf));
                    model_dig = popped.digits;
                end
                busy_cnt = 0;
            end
            if (Busy) busy_cnt++;
            check("digit_select", int'(DigitSelect), 1 << ((n / R) % D));
            check("number", int'(Number), exp_number((n / R) % D));
        end
    end

    // Issue a one-cycle Load; push the expectation only if it should be accepted.
    task automatic do_load(input int v, input bit blank, input bit push);
        exp_t e;
        int   p;
        @(posedge Clock);
        #1;
        Value      = W'(v);
        Load       = 1'b1;
        BlankZeros = blank;
        @(posedge Clock);
        #1;
        Load = 1'b0;
        if (push) begin
            e.ovf = (v > 9999);
            p = 1;
            for (int i = 0; i < D; i++) begin
                e.digits[i] = e.ovf ? -1 : (v / p) % 10;
                p = p * 10;
            end
            e.load_cyc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done();
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge Clock);
        check("done_timeout_pending", sb.size(), 0);
        sb.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_number"}, int'(Number), 0);
        check({tag, "_select"}, int'(DigitSelect), 1);
        check({tag, "_busy"}, int'(Busy), 0);
        check({tag, "_done"}, int'(Done), 0);
        check({tag, "_overflow"}, int'(Overflow), 0);
    endtask

    initial begin
        repeat (3) @(posedge Clock);
        #1;
        check_reset_outputs("reset");
        @(negedge Clock);
        ResetN = 1'b1;

        // 1234 and two full scan frames
        do_load(1234, 1'b0, 1'b1);
        wait_done();
        repeat (2 * D * R) @(posedge Clock);

        // 7 with and without leading-zero blanking
        do_load(7, 1'b1, 1'b1);
        wait_done();
        repeat (D * R) @(posedge Clock);
        @(posedge Clock);
        #1;
        BlankZeros = 1'b0;
        repeat (D * R) @(posedge Clock);

        // Overflow, then the largest in-range value
        do_load(10000, 1'b0, 1'b1);
        wait_done();
        repeat (D * R) @(posedge Clock);

        // Asynchronous mid-cycle reset from a non-zero state
        @(posedge Clock);
        #2;
        ResetN = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge Clock);
        ResetN = 1'b1;

        do_load(9999, 1'b0, 1'b1);
        wait_done();
        repeat (D * R) @(posedge Clock);

        // Load during SHIFT is ignored
        do_load(1234, 1'b0, 1'b1);
        repeat (2) @(posedge Clock);
        do_load(5, 1'b0, 1'b0);
        wait_done();
        repeat (D * R + 10) @(posedge Clock);

        // Reset mid-SHIFT discards the conversion
        do_load(1234, 1'b0, 1'b1);
        repeat (5) @(posedge Clock);
        #3;
        ResetN = 1'b0;
        #1;
        check_reset_outputs("shift_reset");
        @(negedge Clock);
        ResetN = 1'b1;
        repeat (30) @(posedge Clock);
        do_load(42, 1'b0, 1'b1);
        wait_done();
        repeat (D * R) @(posedge Clock);

        // Randomized values and blanking
        for (int t = 0; t < 25; t++) begin
            do_load(int'($urandom_range(0, 16383)), 1'($urandom_range(0, 1)), 1'b1);
            wait_done();
            repeat ($urandom_range(0, 20)) @(posedge Clock);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
